// File: rtl/blind_spot_indicator.sv
// blind_spot_indicator
//   Decodes the 2-bit blind-spot code from the body control module into
//   left/right mirror warning lamps and a chime request. Each side runs its
//   own FSM. A lamp is steady while its side is occupied, and it flashes
//   while the driver signals a turn toward that side. After the side clears,
//   the lamp is held lit for HOLD_CYCLES cycles.
//
// Ports
//   CLK         system clock, rising edge
//   RST         synchronous active-high reset
//   blind[1:0]  00 off, 01 right, 10 left, 11 both
//   turn_right  right turn signal
//   turn_left   left turn signal
//   lamp_right  right mirror lamp (registered)
//   lamp_left   left mirror lamp (registered)
//   chime       audible warning request (registered)
//
// Per-side FSM
//   state    | meaning
//   S_IDLE   | side clear, lamp off
//   S_STEADY | side occupied, no turn toward it, lamp on
//   S_FLASH  | side occupied with turn toward it, lamp = phase
//   S_HOLD   | side just cleared, lamp held on for HOLD_CYCLES
module blind_spot_indicator #(
    parameter int FLASH_HALF  = 4,
    parameter int HOLD_CYCLES = 3,
    parameter int CHIME_LEN   = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] blind,
    input  logic       turn_right,
    input  logic       turn_left,
    output logic       lamp_right,
    output logic       lamp_left,
    output logic       chime
);

    localparam int FW = (FLASH_HALF  > 1) ? $clog2(FLASH_HALF)  : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int CW = (CHIME_LEN   > 1) ? $clog2(CHIME_LEN)   : 1;

    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CHIME_LAST = CW'(CHIME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STEADY = 2'd1,
        S_FLASH  = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    // Index 0 is the right side and index 1 is the left side. This matches the bit order of blind.
    state_t          state_q     [2];
    state_t          state_d     [2];
    logic [FW-1:0]   flash_cnt_q [2];
    logic [FW-1:0]   flash_cnt_d [2];
    logic [HW-1:0]   hold_cnt_q  [2];
    logic [HW-1:0]   hold_cnt_d  [2];
    logic [1:0]      phase_q, phase_d;
    logic [1:0]      lamp_q, lamp_d;
    logic            chime_q, chime_d;
    logic [CW-1:0]   chime_cnt_q, chime_cnt_d;

    logic [1:0]      occ;
    logic [1:0]      turn;
    logic [1:0]      flash_entry;

    assign occ  = blind;
    // Hazard (both turn signals) counts as no turn on either side.
    assign turn = {turn_left & ~turn_right, turn_right & ~turn_left};

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            state_d[s]     = state_q[s];
            flash_cnt_d[s] = flash_cnt_q[s];
            hold_cnt_d[s]  = hold_cnt_q[s];
            phase_d[s]     = phase_q[s];
            lamp_d[s]      = 1'b0;

            case (state_q[s])
                S_IDLE: begin
                    if (occ[s] && turn[s])  state_d[s] = S_FLASH;
                    else if (occ[s])        state_d[s] = S_STEADY;
                end
                S_STEADY: begin
                    if (!occ[s])            state_d[s] = S_HOLD;
                    else if (turn[s])       state_d[s] = S_FLASH;
                end
                S_FLASH: begin
                    if (!occ[s])            state_d[s] = S_HOLD;
                    else if (!turn[s])      state_d[s] = S_STEADY;
                    else if (flash_cnt_q[s] == FLASH_LAST) begin
                        phase_d[s]     = ~phase_q[s];
                        flash_cnt_d[s] = '0;
                    end else begin
                        flash_cnt_d[s] = flash_cnt_q[s] + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (occ[s] && turn[s])  state_d[s] = S_FLASH;
                    else if (occ[s])        state_d[s] = S_STEADY;
                    else if (hold_cnt_q[s] == '0) state_d[s] = S_IDLE;
                    else                    hold_cnt_d[s] = hold_cnt_q[s] - 1'b1;
                end
                default: state_d[s] = S_IDLE;
            endcase

            flash_entry[s] = (state_d[s] == S_FLASH) && (state_q[s] != S_FLASH);

            // Each flash episode starts with a complete on-period.
            if (flash_entry[s]) begin
                phase_d[s]     = 1'b1;
                flash_cnt_d[s] = '0;
            end
            if ((state_d[s] == S_HOLD) && (state_q[s] != S_HOLD)) begin
                hold_cnt_d[s] = HOLD_LAST;
            end

            // The lamp is decoded from the next state. This makes it a registered output.
            case (state_d[s])
                S_STEADY: lamp_d[s] = 1'b1;
                S_FLASH:  lamp_d[s] = phase_d[s];
                S_HOLD:   lamp_d[s] = 1'b1;
                default:  lamp_d[s] = 1'b0;
            endcase
        end
    end

    // If both sides enter flash on the same edge, they produce one shared chime.
    // A new trigger reloads the counter, which extends an active pulse.
    always_comb begin
        chime_d     = chime_q;
        chime_cnt_d = chime_cnt_q;
        if (|flash_entry) begin
            chime_d     = 1'b1;
            chime_cnt_d = CHIME_LAST;
        end else if (chime_q) begin
            if (chime_cnt_q == '0) chime_d = 1'b0;
            else                   chime_cnt_d = chime_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < 2; s++) begin
                state_q[s]     <= S_IDLE;
                flash_cnt_q[s] <= '0;
                hold_cnt_q[s]  <= '0;
            end
            phase_q     <= '0;
            lamp_q      <= '0;
            chime_q     <= 1'b0;
            chime_cnt_q <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                state_q[s]     <= state_d[s];
                flash_cnt_q[s] <= flash_cnt_d[s];
                hold_cnt_q[s]  <= hold_cnt_d[s];
            end
            phase_q     <= phase_d;
            lamp_q      <= lamp_d;
            chime_q     <= chime_d;
            chime_cnt_q <= chime_cnt_d;
        end
    end

    assign lamp_right = lamp_q[0];
    assign lamp_left  = lamp_q[1];
    assign chime      = chime_q;

endmodule

// File: tb/tb_blind_spot_indicator.sv
// tb_blind_spot_indicator
//   Directed sequences followed by randomized stimulus. Outputs are compared
//   every cycle against a timestamp-based reference model. The model keeps a
//   mode for each side and derives the lamp and chime from elapsed cycles
//   since flash entry, hold entry and the last chime trigger.
module tb_blind_spot_indicator;

    localparam int FLASH_HALF  = 4;
    localparam int HOLD_CYCLES = 3;
    localparam int CHIME_LEN   = 2;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] blind;
    logic       turn_right;
    logic       turn_left;
    logic       lamp_right;
    logic       lamp_left;
    logic       chime;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;

    // Reference model state. Mode values: 0 = idle, 1 = steady, 2 = flash, 3 = hold.
    int m_mode   [2];
    int m_fstart [2];
    int m_hstart [2];
    int m_last_chime;
    bit m_chime_valid;
    bit e_lamp [2];
    bit e_chime;

    blind_spot_indicator #(
        .FLASH_HALF (FLASH_HALF),
        .HOLD_CYCLES(HOLD_CYCLES),
        .CHIME_LEN  (CHIME_LEN)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .blind     (blind),
        .turn_right(turn_right),
        .turn_left (turn_left),
        .lamp_right(lamp_right),
        .lamp_left (lamp_left),
        .chime     (chime)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%0b exp=%0b", tag, t, got, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit [1:0] b, input bit tr_in, input bit tl_in);
        bit tr, tl, occ, trn, entered;
        if (rst) begin
            m_mode[0] = 0;
            m_mode[1] = 0;
            m_chime_valid = 0;
            e_lamp[0] = 0;
            e_lamp[1] = 0;
            e_chime = 0;
            return;
        end
        tr = tr_in && !tl_in;
        tl = tl_in && !tr_in;
        entered = 0;
        for (int s = 0; s < 2; s++) begin
            occ = b[s];
            trn = (s == 0) ? tr : tl;
            case (m_mode[s])
                0: begin
                    if (occ && trn) begin m_mode[s] = 2; m_fstart[s] = t; entered = 1; end
                    else if (occ) m_mode[s] = 1;
                end
                1: begin
                    if (!occ) begin m_mode[s] = 3; m_hstart[s] = t; end
                    else if (trn) begin m_mode[s] = 2; m_fstart[s] = t; entered = 1; end
                end
                2: begin
                    if (!occ) begin m_mode[s] = 3; m_hstart[s] = t; end
                    else if (!trn) m_mode[s] = 1;
                end
                default: begin
                    if (occ && trn) begin m_mode[s] = 2; m_fstart[s] = t; entered = 1; end
                    else if (occ) m_mode[s] = 1;
                    else if (t - m_hstart[s] >= HOLD_CYCLES) m_mode[s] = 0;
                end
            endcase
            case (m_mode[s])
                0:       e_lamp[s] = 0;
                2:       e_lamp[s] = (((t - m_fstart[s]) / FLASH_HALF) % 2) == 0;
                default: e_lamp[s] = 1;
            endcase
        end
        if (entered) begin
            m_last_chime  = t;
            m_chime_valid = 1;
        end
        e_chime = m_chime_valid && ((t - m_last_chime) < CHIME_LEN);
    endtask

    task automatic cycle(input bit rst, input bit [1:0] b, input bit tr, input bit tl);
        RST        = rst;
        blind      = b;
        turn_right = tr;
        turn_left  = tl;
        @(posedge CLK);
        t++;
        model_step(rst, b, tr, tl);
        #1;
        chk("lamp_right", lamp_right, e_lamp[0]);
        chk("lamp_left",  lamp_left,  e_lamp[1]);
        chk("chime",      chime,      e_chime);
    endtask

    task automatic run(input bit rst, input bit [1:0] b, input bit tr, input bit tl, input int n);
        for (int i = 0; i < n; i++) cycle(rst, b, tr, tl);
    endtask

    initial begin
        bit [1:0] rb;
        bit       rtr, rtl, rrst;
        int       chime_hi;

        m_last_chime  = -100;
        m_chime_valid = 0;

        // Reset, then idle.
        run(1, 2'b00, 0, 0, 2);
        run(0, 2'b00, 0, 0, 10);

        // Steady right, then hold.
        run(0, 2'b01, 0, 0, 5);
        run(0, 2'b00, 0, 0, 6);

        // Left flash with chime. Dropping the turn returns the lamp to steady.
        cycle(0, 2'b10, 0, 1);
        chk("flash_first_on", lamp_left, 1'b1);
        chk("chime_first",    chime,     1'b1);
        run(0, 2'b10, 0, 1, 19);
        run(0, 2'b10, 0, 0, 3);
        run(0, 2'b00, 0, 0, 5);

        // Hazard with both sides occupied, then release the right turn signal.
        run(0, 2'b11, 1, 1, 4);
        chime_hi = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(0, 2'b11, 0, 1);
            if (chime) chime_hi++;
        end
        chk("hazard_release_one_chime", chime_hi == CHIME_LEN, 1'b1);
        run(0, 2'b00, 0, 0, 5);

        // Re-occupancy during hold, first without and then with a turn signal.
        run(0, 2'b01, 0, 0, 3);
        run(0, 2'b00, 0, 0, 1);
        cycle(0, 2'b01, 0, 0);
        chk("reocc_lamp_held", lamp_right, 1'b1);
        run(0, 2'b01, 0, 0, 2);
        run(0, 2'b01, 1, 0, 3);
        run(0, 2'b00, 1, 0, 1);
        cycle(0, 2'b01, 1, 0);
        chk("reflash_chime", chime, 1'b1);
        run(0, 2'b01, 1, 0, 5);
        run(0, 2'b00, 0, 0, 5);

        // Reset while flashing with the chime active.
        run(0, 2'b10, 0, 1, 1);
        cycle(1, 2'b10, 0, 1);
        chk("rst_mid_flash_lamp",  lamp_left, 1'b0);
        chk("rst_mid_flash_chime", chime,     1'b0);
        run(0, 2'b00, 0, 0, 5);

        // Randomized stimulus. Inputs change only occasionally so that flash and hold periods can run their full length.
        rb = 2'b00; rtr = 0; rtl = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0)  rb  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)  rtr = ~rtr;
            if ($urandom_range(0, 9) == 0)  rtl = ~rtl;
            rrst = ($urandom_range(0, 299) == 0);
            cycle(rrst, rb, rtr, rtl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/blind_spot_indicator.md
Name: blind_spot_indicator

Overview:
Consumer end of the 2-bit blind-spot code produced by the body control module's blind-spot monitor. Decodes the code into independent left and right side-mirror lamp drives and an audible chime.
- Lamp steady while a side is occupied.
- Lamp flashes when the driver signals a turn toward an occupied side.
- Minimum lamp hold after a side clears, to suppress lamp chatter.

Parameters:
FLASH_HALF, 4, cycles per flash half-period (lamp on FLASH_HALF, off FLASH_HALF); must be >= 1
HOLD_CYCLES, 3, cycles the lamp stays lit after its side clears; must be >= 1
CHIME_LEN, 2, cycles chime stays high per trigger; must be >= 1

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous, active-high reset
blind  input  2  blind-spot code: 00 OFF, 01 RIGHT, 10 LEFT, 11 RIGHT_LEFT
turn_right  input  1  right turn signal active
turn_left  input  1  left turn signal active
lamp_right  output  1  right mirror warning lamp
lamp_left  output  1  left mirror warning lamp
chime  output  1  audible warning request

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RST. RST has priority over all other logic and is evaluated only on a CLK rising edge.
- On reset:
  - both side FSMs go to IDLE
  - lamp_right, lamp_left and chime are 0
  - flash, hold and chime counters are 0; flash phases are 0.
- Decode: occ_right = blind[0], occ_left = blind[1].
- Effective turn: tr = turn_right & ~turn_left; tl = turn_left & ~turn_right. Both turn signals high (hazard) counts as no turn on either side.
- Two identical, independent per-side FSMs. For each side: occ = that side's occupancy bit, turn = that side's effective turn.
- FSM states and transitions, evaluated every edge:
  - IDLE: lamp 0. If occ & turn, go to FLASH. Else if occ, go to STEADY.
  - STEADY: lamp 1. If !occ, go to HOLD. Else if turn, go to FLASH.
  - FLASH: lamp = phase. If !occ, go to HOLD. Else if !turn, go to STEADY.
  - HOLD: lamp 1. If occ & turn, go to FLASH. Else if occ, go to STEADY. Else if hold_cnt == 0, go to IDLE. Else hold_cnt decrements.
- All outputs are registered and decoded from the next state, so there is 1-cycle latency from input to output. The lamp value shown below is the value on the edge the state is entered.
- FLASH entry: phase = 1 (lamp on), flash_cnt = 0.
  - While in FLASH: if flash_cnt == FLASH_HALF-1, toggle phase and clear flash_cnt; else increment flash_cnt.
  - The first on-period is exactly FLASH_HALF cycles.
- HOLD entry: hold_cnt = HOLD_CYCLES-1 and lamp = 1, including on FLASH->HOLD when phase was 0. Lamp stays 1 for exactly HOLD_CYCLES cycles, then IDLE if still unoccupied.
- Chime:
  - On any edge where either side enters FLASH (from any state), chime = 1 and chime_cnt = CHIME_LEN-1.
  - Otherwise, while chime = 1: if chime_cnt == 0, chime = 0; else decrement.
  - Both sides entering FLASH on the same edge produce one chime.
  - A trigger during an active chime reloads the counter, extending the pulse.
  - Remaining in FLASH does not retrigger.
  - Every re-entry into FLASH retriggers, e.g. turn toggled STEADY->FLASH or HOLD->FLASH.
- Simultaneous events: blind changing and a turn change on the same edge follow the priority order listed per state above.
- Counter widths: each counter is sized by clog2 of its parameter, minimum 1 bit. No counter wraps past its reload value.

Test Plan:
1. Reset then idle: RST=1 for 2 cycles, then blind=00, no turns for 10 cycles -> lamps and chime 0 throughout.
2. Steady and hold (HOLD_CYCLES=3): blind=01 at edge 0 -> lamp_right=1 from edge 1, lamp_left=0. blind=00 at edge 5 -> lamp_right stays 1 through edge 8 and is 0 at edge 9. chime never asserts.
3. Flash and chime (FLASH_HALF=4, CHIME_LEN=2): blind=10, turn_left=1 from idle -> at edge 1:
   - lamp_left=1 for 4 cycles, then 0 for 4 cycles, repeating
   - chime=1 on edges 1-2, then 0.
   Dropping turn_left -> lamp_left=1 steady the next cycle.
4. Hazard and both sides: blind=11, turn_left=turn_right=1 -> both lamps steady 1, chime 0. Releasing turn_right -> only the left lamp flashes, one 2-cycle chime.
5. Re-occupancy during hold: blind 01 -> 00 -> 01 with 1-cycle gap, HOLD_CYCLES=3 -> lamp_right stays 1 continuously and never reaches IDLE. Same sequence with turn_right=1 -> FLASH re-entry and a new chime.
6. Reset mid-flash: RST=1 while in FLASH with chime active -> next edge lamps=0, chime=0. After release with blind=00, all outputs stay 0.
